operator_slot_sequencer: RTL and testbench
==========================================

Name: operator_slot_sequencer

Overview:
- Sequences the shared operator datapath (phase generator, envelope, output mixer) across all operator slots once per sample period.
- On each sample tick it walks slots 0..NUM_OPERATORS-1 at a fixed issue spacing.
- For every slot it drives op_num, a per-slot enable pulse, the channel number, modulator/carrier role and rhythm operator type.
- It flags end-of-sample once the datapath pipeline has drained, so the channel accumulator can latch its sums.

Parameters:
- NUM_OPERATORS, 18: slots per sample sweep.
- OP_SPACING, 4: clock cycles between successive slot issues; legal range 1..15.
- DRAIN_CYCLES, 6: datapath latency from slot issue to operator output valid.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- sample_clk_en, input, 1: one-cycle sample tick that starts a sweep.
- rhythm_en, input, 1: rhythm-mode register bit, sampled at sweep start.
- op_sample_clk_en, output, 1: one-cycle pulse on the issue cycle of each slot.
- op_num, output, 5: current slot number, held stable between issues.
- ch_num, output, 4: channel owning op_num.
- op_is_carrier, output, 1: 1 means carrier, 0 means modulator.
- op_type, output, operator_t: OP_NORMAL or the rhythm type for this slot.
- busy, output, 1: a sweep or its drain is in progress.
- sample_done, output, 1: one-cycle pulse once the last slot's output is valid.
- overrun, output, 1: sticky flag; a sample tick arrived while busy.

Behaviour:
- Reset values: op_sample_clk_en=0, op_num=0, ch_num=0, op_is_carrier=0, op_type=OP_NORMAL, busy=0, sample_done=0, overrun=0. Reset also forces state IDLE and zeroes all counters.
- State machine:
  - IDLE -> ISSUE on sample_clk_en.
  - ISSUE -> DRAIN after the slot NUM_OPERATORS-1 issue.
  - DRAIN -> IDLE when the drain counter expires.
- Entering ISSUE:
  - Latch rhythm_en into rhythm_q; it is held for the whole sweep, so mid-sweep changes take effect next sweep.
  - Set slot=0 and spacing counter=0.
- ISSUE timing:
  - Issue cycle k = (cycle after the tick) + k*OP_SPACING, for k=0..NUM_OPERATORS-1.
  - On each issue cycle: op_sample_clk_en=1, and op_num, ch_num, op_is_carrier and op_type take slot k's values (registered outputs, same cycle as the pulse).
  - Between issue cycles: op_sample_clk_en=0 and the other slot outputs hold.
  - The spacing counter wraps at OP_SPACING-1. With OP_SPACING=1, issues fall on consecutive cycles.
- DRAIN: counts DRAIN_CYCLES cycles from the last issue cycle. sample_done pulses exactly DRAIN_CYCLES cycles after the last issue, and DRAIN exits to IDLE in that same cycle.
- busy is 1 from the first issue cycle through the sample_done cycle inclusive, and 0 otherwise.
- Slot mapping, for n = 0..17:
  - ch_num = (n/6)*3 + (n mod 3).
  - op_is_carrier = (n mod 6) >= 3.
- op_type:
  - rhythm_q=0: OP_NORMAL for all slots.
  - rhythm_q=1: slots 12 and 15 = OP_BASS_DRUM; 13 = OP_HI_HAT; 16 = OP_SNARE_DRUM; 14 = OP_TOM_TOM; 17 = OP_TOP_CYMBAL. All others OP_NORMAL.
- Tick while busy:
  - The tick is ignored; the current sweep continues unaltered and overrun is set.
  - overrun is cleared only by reset.
  - A tick in the same cycle that sample_done pulses also counts as an overrun and is dropped.
- Tick arriving in IDLE the cycle after sample_done: accepted normally.
- Reset mid-sweep: all outputs return to reset values the next cycle. No sample_done is emitted for the aborted sweep.

Test Plan:
- Reset, then one sample_clk_en with OP_SPACING=4 and DRAIN_CYCLES=6 -> 18 op_sample_clk_en pulses at tick+1+4k. op_num runs 0..17. ch_num runs 0,1,2,0,1,2,3,4,5,3,4,5,6,7,8,6,7,8. op_is_carrier is 0 for slots 0-2, 1 for 3-5, and so on. sample_done fires at tick+1+68+6 = tick+75, and busy falls after that cycle.
- rhythm_en=1 at the tick -> op_type is OP_BASS_DRUM at slots 12 and 15, HI_HAT at 13, TOM_TOM at 14, SNARE_DRUM at 16, TOP_CYMBAL at 17, OP_NORMAL elsewhere. Toggling rhythm_en to 0 at slot 5 changes nothing until the next sweep.
- Second tick at slot 9 -> overrun=1 and stays 1. The sweep completes with exactly 18 pulses and one sample_done.
- Tick coincident with sample_done -> dropped and overrun set. A tick one cycle later -> new sweep with first issue the following cycle.
- reset asserted at slot 10 -> all outputs at reset values the next cycle and no sample_done. A subsequent tick restarts from op_num=0.
- OP_SPACING=1 build -> 18 consecutive pulses on cycles tick+1..tick+18, and sample_done at tick+24.

Source files
------------

// File: rtl/operator_slot_sequencer.sv
// Walks the shared operator datapath across every slot once per sample tick and
// flags end-of-sample after the pipeline has drained.
package operator_slot_sequencer_pkg;
    typedef enum logic [2:0] {
        OP_NORMAL     = 3'd0,
        OP_BASS_DRUM  = 3'd1,
        OP_SNARE_DRUM = 3'd2,
        OP_TOM_TOM    = 3'd3,
        OP_TOP_CYMBAL = 3'd4,
        OP_HI_HAT     = 3'd5
    } operator_t;
endpackage

module operator_slot_sequencer
    import operator_slot_sequencer_pkg::*;
#(
    parameter int NUM_OPERATORS = 18,
    parameter int OP_SPACING    = 4,
    parameter int DRAIN_CYCLES  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_clk_en,
    input  logic       rhythm_en,
    output logic       op_sample_clk_en,
    output logic [4:0] op_num,
    output logic [3:0] ch_num,
    output logic       op_is_carrier,
    output operator_t  op_type,
    output logic       busy,
    output logic       sample_done,
    output logic       overrun
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [4:0]    LAST_SLOT  = 5'(NUM_OPERATORS - 1);
    localparam logic [3:0]    SPC_LAST   = 4'(OP_SPACING - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_q;
    logic [4:0]    slot_q;
    logic [4:0]    slot_d;
    logic [3:0]    spc_q;
    logic [DW-1:0] drn_q;
    logic          rhythm_q;

    logic          pulse_q;
    logic [4:0]    op_num_q;
    logic [3:0]    ch_num_q;
    logic          carrier_q;
    operator_t     type_q;
    logic          busy_q;
    logic          done_q;
    logic          overrun_q;

    // Channels 0-2 own slots {0,3},{1,4},{2,5}; each group of six slots covers three channels.
    function automatic logic [3:0] slot_ch(input logic [4:0] n);
        int v;
        v = int'(n);
        return 4'((v / 6) * 3 + (v % 3));
    endfunction

    function automatic logic slot_carrier(input logic [4:0] n);
        int v;
        v = int'(n);
        return (v % 6) >= 3;
    endfunction

    function automatic operator_t slot_type(input logic [4:0] n, input logic rhy);
        operator_t t;
        t = OP_NORMAL;
        if (rhy) begin
            case (n)
                5'd12, 5'd15: t = OP_BASS_DRUM;
                5'd13:        t = OP_HI_HAT;
                5'd14:        t = OP_TOM_TOM;
                5'd16:        t = OP_SNARE_DRUM;
                5'd17:        t = OP_TOP_CYMBAL;
                default:      t = OP_NORMAL;
            endcase
        end
        return t;
    endfunction

    always_comb begin
        slot_d = slot_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            spc_q     <= '0;
            drn_q     <= '0;
            rhythm_q  <= 1'b0;
            pulse_q   <= 1'b0;
            op_num_q  <= '0;
            ch_num_q  <= '0;
            carrier_q <= 1'b0;
            type_q    <= OP_NORMAL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            // busy_q also covers the sample_done cycle, so a tick there is dropped too.
            if (sample_clk_en && busy_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sample_clk_en && !busy_q) begin
                        state_q   <= ISSUE;
                        rhythm_q  <= rhythm_en;
                        slot_q    <= '0;
                        spc_q     <= '0;
                        busy_q    <= 1'b1;
                        pulse_q   <= 1'b1;
                        op_num_q  <= '0;
                        ch_num_q  <= slot_ch(5'd0);
                        carrier_q <= slot_carrier(5'd0);
                        type_q    <= slot_type(5'd0, rhythm_en);
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (spc_q == SPC_LAST) begin
                        spc_q     <= '0;
                        slot_q    <= slot_d;
                        pulse_q   <= 1'b1;
                        op_num_q  <= slot_d;
                        ch_num_q  <= slot_ch(slot_d);
                        carrier_q <= slot_carrier(slot_d);
                        type_q    <= slot_type(slot_d, rhythm_q);
                        if (slot_d == LAST_SLOT) begin
                            state_q <= DRAIN;
                            drn_q   <= '0;
                        end
                    end else begin
                        spc_q <= spc_q + 4'd1;
                    end
                end
                DRAIN: begin
                    if (drn_q == DRAIN_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        drn_q <= drn_q + DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_sample_clk_en = pulse_q;
    assign op_num           = op_num_q;
    assign ch_num           = ch_num_q;
    assign op_is_carrier    = carrier_q;
    assign op_type          = type_q;
    assign busy             = busy_q;
    assign sample_done      = done_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_operator_slot_sequencer.sv
// Bench for operator_slot_sequencer: two builds (spacing 4 and spacing 1) share the
// same stimulus; a sweep-level scoreboard predicts every pulse, held value and done.
module tb_operator_slot_sequencer;
    import operator_slot_sequencer_pkg::*;

    localparam int NOPS  = 18;
    localparam int DRAIN = 6;
    localparam int SP [2] = '{4, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_clk_en = 1'b0;
    logic rhythm_en = 1'b0;

    logic       pls [2];
    logic [4:0] opn [2];
    logic [3:0] chn [2];
    logic       car [2];
    operator_t  typ [2];
    logic       bsy [2];
    logic       dne [2];
    logic       ovr [2];

    operator_slot_sequencer #(.NUM_OPERATORS(NOPS), .OP_SPACING(4), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .rhythm_en(rhythm_en),
        .op_sample_clk_en(pls[0]), .op_num(opn[0]), .ch_num(chn[0]), .op_is_carrier(car[0]),
        .op_type(typ[0]), .busy(bsy[0]), .sample_done(dne[0]), .overrun(ovr[0]));

    operator_slot_sequencer #(.NUM_OPERATORS(NOPS), .OP_SPACING(1), .DRAIN_CYCLES(DRAIN)) dut_sp1 (
        .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .rhythm_en(rhythm_en),
        .op_sample_clk_en(pls[1]), .op_num(opn[1]), .ch_num(chn[1]), .op_is_carrier(car[1]),
        .op_type(typ[1]), .busy(bsy[1]), .sample_done(dne[1]), .overrun(ovr[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] op;
        logic [3:0] ch;
        logic       car;
        operator_t  ty;
    } iss_t;

    // Channel/role tables written out slot by slot.
    localparam int CH_TAB [NOPS] = '{0,1,2,0,1,2,3,4,5,3,4,5,6,7,8,6,7,8};
    localparam int CAR_TAB[NOPS] = '{0,0,0,1,1,1,0,0,0,1,1,1,0,0,0,1,1,1};

    iss_t       iq [2][$];
    int         dq [2][$];
    logic [4:0] h_op [2];
    logic [3:0] h_ch [2];
    logic       h_car [2];
    operator_t  h_ty [2];
    bit         act [2];
    int         st [2];
    int         dn [2];
    bit         m_ov [2];
    bit         rst_d = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic operator_t exp_type(int n, bit r);
        if (!r) return OP_NORMAL;
        case (n)
            12, 15:  return OP_BASS_DRUM;
            13:      return OP_HI_HAT;
            14:      return OP_TOM_TOM;
            16:      return OP_SNARE_DRUM;
            17:      return OP_TOP_CYMBAL;
            default: return OP_NORMAL;
        endcase
    endfunction

    task automatic chk(string nm, int d, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, a, e);
        end
    endtask

    task automatic model_reset(int d);
        iq[d].delete();
        dq[d].delete();
        h_op[d] = '0; h_ch[d] = '0; h_car[d] = 1'b0; h_ty[d] = OP_NORMAL;
        act[d] = 1'b0; m_ov[d] = 1'b0; st[d] = 0; dn[d] = 0;
    endtask

    task automatic model_tick(int d, bit r);
        iss_t e;
        if (act[d] && cyc <= dn[d]) begin
            m_ov[d] = 1'b1;
        end else begin
            act[d] = 1'b1;
            st[d]  = cyc + 1;
            dn[d]  = cyc + 1 + (NOPS - 1) * SP[d] + DRAIN;
            for (int k = 0; k < NOPS; k++) begin
                e.at  = cyc + 1 + k * SP[d];
                e.op  = 5'(k);
                e.ch  = 4'(CH_TAB[k]);
                e.car = CAR_TAB[k] != 0;
                e.ty  = exp_type(k, r);
                iq[d].push_back(e);
            end
            dq[d].push_back(dn[d]);
        end
    endtask

    task automatic check_dut(int d);
        bit ep, ed, eb;
        ep = iq[d].size() > 0 && iq[d][0].at == cyc;
        if (ep) begin
            h_op[d]  = iq[d][0].op;
            h_ch[d]  = iq[d][0].ch;
            h_car[d] = iq[d][0].car;
            h_ty[d]  = iq[d][0].ty;
            void'(iq[d].pop_front());
        end
        ed = dq[d].size() > 0 && dq[d][0] == cyc;
        if (ed) void'(dq[d].pop_front());
        eb = act[d] && cyc >= st[d] && cyc <= dn[d];
        chk("op_sample_clk_en", d, 32'(pls[d]), 32'(ep));
        chk("op_num", d, 32'(opn[d]), 32'(h_op[d]));
        chk("ch_num", d, 32'(chn[d]), 32'(h_ch[d]));
        chk("op_is_carrier", d, 32'(car[d]), 32'(h_car[d]));
        chk("op_type", d, 32'(typ[d]), 32'(h_ty[d]));
        chk("busy", d, 32'(bsy[d]), 32'(eb));
        chk("sample_done", d, 32'(dne[d]), 32'(ed));
        chk("overrun", d, 32'(ovr[d]), 32'(m_ov[d]));
    endtask

    // Monitor: model updates from last cycle's reset, compare, then absorb this cycle's inputs.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                if (rst_d) model_reset(d);
                check_dut(d);
            end
            rst_d = reset;
            if (!reset && sample_clk_en) begin
                for (int d = 0; d < 2; d++) model_tick(d, rhythm_en);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample_clk_en = 1'b1;
        step(1);
        sample_clk_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        // Plain sweep.
        rhythm_en = 1'b0;
        tick();
        step(80);

        // Rhythm sweep, rhythm toggled at slot 5, overrun at slot 9,
        // tick coincident with sample_done, then back-to-back accepted tick.
        rhythm_en = 1'b1;
        tick();
        step(20);
        rhythm_en = 1'b0;
        step(16);
        tick();
        step(37);
        tick();
        tick();

        // Reset at slot 10 of the new sweep, then a fresh sweep.
        step(40);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(3);
        rhythm_en = 1'b1;
        tick();
        step(80);

        for (int i = 0; i < 30; i++) begin
            rhythm_en = 1'($urandom_range(0, 1));
            tick();
            step($urandom_range(1, 90));
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 2));
                reset = 1'b0;
                step(1);
            end
        end
        step(100);

        for (int d = 0; d < 2; d++) begin
            chk("issues_outstanding", d, 32'(iq[d].size()), 32'd0);
            chk("done_outstanding", d, 32'(dq[d].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
